pc_redirect_ctrl: RTL and testbench

//   Next-PC sequencer for the 5-stage pipeline: computes the value loaded into the PC

---
 rtl/pc_redirect_if.sv | 31 +++
 rtl/pc_redirect_ctrl.sv | 122 ++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_redirect_if.sv
// Next-PC control bundle: PC/stall/redirect inputs toward the sequencer,
// new PC, hold and flush controls back toward the pipeline.
interface pc_redirect_if;
    logic [31:0] pc_cur;
    logic        icache_stall;
    logic        dcache_stall;
    logic        hazard_stall;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        br_valid;
    logic [31:0] br_target;
    logic        trap_valid;
    logic [31:0] trap_vec;
    logic [31:0] new_pc;
    logic        pc_hold;
    logic        flush_if;
    logic        flush_id;
    logic        redir_pending;

    modport master (
        output pc_cur, icache_stall, dcache_stall, hazard_stall,
        output jmp_valid, jmp_target, br_valid, br_target, trap_valid, trap_vec,
        input  new_pc, pc_hold, flush_if, flush_id, redir_pending
    );

    modport slave (
        input  pc_cur, icache_stall, dcache_stall, hazard_stall,
        input  jmp_valid, jmp_target, br_valid, br_target, trap_valid, trap_vec,
        output new_pc, pc_hold, flush_if, flush_id, redir_pending
    );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// Next-PC sequencer: boot hold, sequential fetch, prioritised redirects, and
// capture/replay of a redirect that lands while a cache miss stalls the front end.
module pc_redirect_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BOOT_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    pc_redirect_if.slave bus
);
    localparam int CNT_W = $clog2(BOOT_CYCLES + 1);
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] boot_cnt_q, boot_cnt_d;
    logic [31:0]      pend_pc_q, pend_pc_d;

    logic        stall_any;
    logic        any_redir;
    logic        sel_flush_id;
    logic [31:0] sel_tgt;

    logic [31:0] new_pc;
    logic        pc_hold;
    logic        flush_if;
    logic        flush_id;
    logic        redir_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BOOT;
            boot_cnt_q <= '0;
            pend_pc_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            boot_cnt_q <= boot_cnt_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    // Fixed priority: trap > branch mispredict > jump; jumps leave ID/EX intact.
    always_comb begin
        sel_tgt      = bus.jmp_target;
        sel_flush_id = 1'b0;
        if (bus.trap_valid) begin
            sel_tgt      = bus.trap_vec;
            sel_flush_id = 1'b1;
        end else if (bus.br_valid) begin
            sel_tgt      = bus.br_target;
            sel_flush_id = 1'b1;
        end
    end

    assign stall_any = bus.icache_stall | bus.dcache_stall;
    assign any_redir = bus.trap_valid | bus.br_valid | bus.jmp_valid;

    always_comb begin
        state_d       = state_q;
        boot_cnt_d    = boot_cnt_q;
        pend_pc_d     = pend_pc_q;
        new_pc        = RESET_PC;
        pc_hold       = 1'b1;
        flush_if      = 1'b0;
        flush_id      = 1'b0;
        redir_pending = 1'b0;

        case (state_q)
            BOOT: begin
                boot_cnt_d = boot_cnt_q + CNT_W'(1);
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                if (any_redir) begin
                    new_pc   = sel_tgt;
                    pc_hold  = stall_any;
                    flush_if = 1'b1;
                    flush_id = sel_flush_id;
                    if (stall_any) begin
                        pend_pc_d = sel_tgt;
                        state_d   = PEND;
                    end
                end else begin
                    new_pc  = bus.pc_cur + 32'd4;
                    pc_hold = stall_any | bus.hazard_stall;
                end
            end

            PEND: begin
                // Jump/branch here are wrong-path; only a trap can retarget the replay.
                redir_pending = 1'b1;
                pc_hold       = stall_any;
                new_pc        = pend_pc_q;
                if (bus.trap_valid) begin
                    pend_pc_d = bus.trap_vec;
                    flush_if  = 1'b1;
                    flush_id  = 1'b1;
                end
                if (!stall_any) begin
                    if (bus.trap_valid) begin
                        new_pc = bus.trap_vec;
                    end
                    state_d = RUN;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign bus.new_pc        = new_pc;
    assign bus.pc_hold       = pc_hold;
    assign bus.flush_if      = flush_if;
    assign bus.flush_id      = flush_id;
    assign bus.redir_pending = redir_pending;
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the sequencer.
module tb_pc_redirect_ctrl;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          BOOT_CYCLES = 4;

    logic clk;
    logic rst;
    pc_redirect_if bus ();

    pc_redirect_ctrl #(.RESET_PC(RESET_PC), .BOOT_CYCLES(BOOT_CYCLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Model: cycles of boot hold left, whether a redirect is parked, and where to.
    int          boot_left;
    bit          pend;
    logic [31:0] pend_addr;

    function automatic void model_reset();
        boot_left = BOOT_CYCLES;
        pend      = 1'b0;
        pend_addr = RESET_PC;
    endfunction

    // {found, flushes ID/EX, target} of the highest-priority redirect request.
    function automatic logic [33:0] winner();
        if (bus.trap_valid) return {1'b1, 1'b1, bus.trap_vec};
        if (bus.br_valid)   return {1'b1, 1'b1, bus.br_target};
        if (bus.jmp_valid)  return {1'b1, 1'b0, bus.jmp_target};
        return {2'b00, 32'h0};
    endfunction

    function automatic logic [35:0] model_out();
        logic        stalled;
        logic [33:0] w;
        stalled = bus.icache_stall | bus.dcache_stall;
        w = winner();
        if (boot_left > 0) return {RESET_PC, 1'b1, 3'b000};
        if (pend) return {(!stalled && bus.trap_valid) ? bus.trap_vec : pend_addr,
                          stalled, bus.trap_valid, bus.trap_valid, 1'b1};
        if (w[33]) return {w[31:0], stalled, 1'b1, w[32], 1'b0};
        return {bus.pc_cur + 32'd4, stalled | bus.hazard_stall, 3'b000};
    endfunction

    function automatic void model_update();
        logic        stalled;
        logic [33:0] w;
        stalled = bus.icache_stall | bus.dcache_stall;
        w = winner();
        if (boot_left > 0) begin
            boot_left--;
        end else if (pend) begin
            if (bus.trap_valid) pend_addr = bus.trap_vec;
            if (!stalled) pend = 1'b0;
        end else if (w[33] && stalled) begin
            pend      = 1'b1;
            pend_addr = w[31:0];
        end
    endfunction

    function automatic logic [35:0] dut_out();
        return {bus.new_pc, bus.pc_hold, bus.flush_if, bus.flush_id, bus.redir_pending};
    endfunction

    task automatic clear_inputs();
        bus.pc_cur       = 32'h0;
        bus.icache_stall = 1'b0;
        bus.dcache_stall = 1'b0;
        bus.hazard_stall = 1'b0;
        bus.jmp_valid    = 1'b0;
        bus.jmp_target   = 32'h0;
        bus.br_valid     = 1'b0;
        bus.br_target    = 32'h0;
        bus.trap_valid   = 1'b0;
        bus.trap_vec     = 32'h0;
    endtask

    task automatic sample(output logic [35:0] e);
        @(negedge clk);
        e = model_out();
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) model_reset();
        else model_update();
        #1;
    endtask

    task automatic test_reset();
        logic [35:0] e;
        clear_inputs();
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            sample(e);
            vectors++;
            if (dut_out() !== e) begin
                miscompares++;
                $display("FAIL reset_asserted cyc%0d: got %h want %h", i, dut_out(), e);
            end
            advance();
        end
        rst = 1'b0;
        for (int i = 0; i < BOOT_CYCLES; i++) begin
            sample(e);
            vectors++;
            if (dut_out() !== e) begin
                miscompares++;
                $display("FAIL boot_hold cyc%0d: got %h want %h", i, dut_out(), e);
            end
            advance();
        end
        sample(e);
        vectors++;
        if (dut_out() !== {32'h4, 4'b0000} || dut_out() !== e) begin
            miscompares++;
            $display("FAIL first_fetch: got %h want %h", dut_out(), {32'h4, 4'b0000});
        end
        $display("reset: boot hold %0d cycles then fetch new_pc=%h", BOOT_CYCLES, bus.new_pc);
        advance();
    endtask

    task automatic test_branch();
        logic [35:0] e;
        clear_inputs();
        bus.pc_cur = 32'h40; bus.br_valid = 1'b1; bus.br_target = 32'h100;
        sample(e);
        vectors++;
        if (dut_out() !== {32'h100, 4'b0110} || dut_out() !== e) begin
            miscompares++;
            $display("FAIL branch_redirect: got %h want %h", dut_out(), {32'h100, 4'b0110});
        end
        advance();
        clear_inputs();
        bus.pc_cur = 32'h100;
        sample(e);
        vectors++;
        if (dut_out() !== {32'h104, 4'b0000} || dut_out() !== e) begin
            miscompares++;
            $display("FAIL branch_next: got %h want %h", dut_out(), {32'h104, 4'b0000});
        end
        $display("branch: 0x40 -> 0x100 with flush_if/flush_id, then 0x104");
        advance();
    endtask

    task automatic test_stall_redirect();
        logic [35:0] e;
        clear_inputs();
        bus.pc_cur = 32'h104; bus.icache_stall = 1'b1;
        bus.jmp_valid = 1'b1; bus.jmp_target = 32'h200;
        sample(e);
        vectors++;
        if (dut_out() !== e || bus.flush_if !== 1'b1 || bus.flush_id !== 1'b0) begin
            miscompares++;
            $display("FAIL jump_capture: got %h want %h", dut_out(), e);
        end
        advance();
        bus.jmp_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample(e);
            vectors++;
            if (dut_out() !== e || dut_out() !== {32'h200, 4'b1001}) begin
                miscompares++;
                $display("FAIL pend_hold cyc%0d: got %h want %h", i, dut_out(), e);
            end
            advance();
        end
        bus.icache_stall = 1'b0;
        sample(e);
        vectors++;
        if (dut_out() !== e || bus.new_pc !== 32'h200 || bus.pc_hold !== 1'b0) begin
            miscompares++;
            $display("FAIL pend_release: got %h want %h", dut_out(), e);
        end
        advance();
        bus.pc_cur = 32'h200;
        sample(e);
        vectors++;
        if (dut_out() !== e || bus.redir_pending !== 1'b0) begin
            miscompares++;
            $display("FAIL after_release: got %h want %h", dut_out(), e);
        end
        $display("stall_redirect: jump 0x200 parked 5 cycles, replayed on stall release");
        advance();
    endtask

    task automatic test_priority();
        logic [35:0] e;
        clear_inputs();
        bus.pc_cur = 32'h204;
        bus.trap_valid = 1'b1; bus.trap_vec   = 32'h80;
        bus.br_valid   = 1'b1; bus.br_target  = 32'h100;
        bus.jmp_valid  = 1'b1; bus.jmp_target = 32'h200;
        sample(e);
        vectors++;
        if (dut_out() !== e || dut_out() !== {32'h80, 4'b0110}) begin
            miscompares++;
            $display("FAIL priority_trap: got %h want %h", dut_out(), e);
        end
        advance();
        clear_inputs();
        bus.pc_cur = 32'h80; bus.dcache_stall = 1'b1;
        bus.jmp_valid = 1'b1; bus.jmp_target = 32'h300;
        sample(e);
        vectors++;
        if (dut_out() !== e) begin
            miscompares++;
            $display("FAIL capture_300: got %h want %h", dut_out(), e);
        end
        advance();
        bus.jmp_valid = 1'b0;
        bus.trap_valid = 1'b1; bus.trap_vec = 32'h80;
        sample(e);
        vectors++;
        if (dut_out() !== e || bus.flush_if !== 1'b1 || bus.flush_id !== 1'b1) begin
            miscompares++;
            $display("FAIL pend_trap: got %h want %h", dut_out(), e);
        end
        advance();
        bus.trap_valid = 1'b0; bus.dcache_stall = 1'b0;
        sample(e);
        vectors++;
        if (dut_out() !== e || dut_out() !== {32'h80, 4'b0001}) begin
            miscompares++;
            $display("FAIL trap_replaced_pend: got %h want %h", dut_out(), e);
        end
        $display("priority: trap wins, pending 0x300 replaced by trap 0x80");
        advance();
    endtask

    task automatic test_hazard();
        logic [35:0] e;
        clear_inputs();
        bus.pc_cur = 32'h80; bus.hazard_stall = 1'b1;
        bus.br_valid = 1'b1; bus.br_target = 32'h500;
        sample(e);
        vectors++;
        if (dut_out() !== e || dut_out() !== {32'h500, 4'b0110}) begin
            miscompares++;
            $display("FAIL hazard_vs_branch: got %h want %h", dut_out(), e);
        end
        advance();
        bus.br_valid = 1'b0; bus.pc_cur = 32'h500;
        sample(e);
        vectors++;
        if (dut_out() !== e || bus.pc_hold !== 1'b1) begin
            miscompares++;
            $display("FAIL hazard_alone: got %h want %h", dut_out(), e);
        end
        $display("hazard: branch overrides hazard hold, hazard alone holds");
        advance();
    endtask

    task automatic test_wrap_reset();
        logic [35:0] e;
        clear_inputs();
        bus.pc_cur = 32'hFFFF_FFFC;
        sample(e);
        vectors++;
        if (dut_out() !== e || bus.new_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL pc_wrap: got %h want %h", dut_out(), e);
        end
        advance();
        bus.icache_stall = 1'b1; bus.br_valid = 1'b1; bus.br_target = 32'h640;
        sample(e);
        advance();
        bus.br_valid = 1'b0;
        sample(e);
        vectors++;
        if (dut_out() !== e || bus.redir_pending !== 1'b1) begin
            miscompares++;
            $display("FAIL pend_before_reset: got %h want %h", dut_out(), e);
        end
        rst = 1'b1;
        #1;
        model_reset();
        e = model_out();
        vectors++;
        if (dut_out() !== e || dut_out() !== {RESET_PC, 4'b1000}) begin
            miscompares++;
            $display("FAIL async_reset: got %h want %h", dut_out(), e);
        end
        advance();
        advance();
        rst = 1'b0;
        bus.icache_stall = 1'b0;
        for (int i = 0; i <= BOOT_CYCLES; i++) begin
            sample(e);
            vectors++;
            if (dut_out() !== e) begin
                miscompares++;
                $display("FAIL reboot cyc%0d: got %h want %h", i, dut_out(), e);
            end
            advance();
        end
        $display("wrap_reset: FFFFFFFC wraps to 0, reset in PEND restarts boot");
    endtask

    task automatic test_random();
        logic [35:0] e;
        int bad;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            rst              = ($urandom_range(99) == 0);
            bus.pc_cur       = $urandom & 32'hFFFF_FFFC;
            bus.icache_stall = ($urandom_range(3) == 0);
            bus.dcache_stall = ($urandom_range(5) == 0);
            bus.hazard_stall = ($urandom_range(3) == 0);
            bus.jmp_valid    = ($urandom_range(4) == 0);
            bus.br_valid     = ($urandom_range(5) == 0);
            bus.trap_valid   = ($urandom_range(9) == 0);
            bus.jmp_target   = $urandom;
            bus.br_target    = $urandom;
            bus.trap_vec     = $urandom;
            #1;
            if (rst) model_reset();
            sample(e);
            vectors++;
            if (dut_out() !== e) begin
                miscompares++;
                bad++;
                $display("FAIL random cyc%0d: got %h want %h", i, dut_out(), e);
            end
            advance();
        end
        rst = 1'b0;
        $display("random: 400 cycles, %0d bad", bad);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        clear_inputs();
        model_reset();
        test_reset();
        test_branch();
        test_stall_redirect();
        test_priority();
        test_hazard();
        test_wrap_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
